// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and sizes for the truth-table sequencer.
package truth_table_sequencer_pkg;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// Dwell counter: counts cycles a vector is held, flags the sample cycle.
module tts_dwell_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Applies all 16 input vectors to a 4-input function, captures its
// truth table and compares it against an expected table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_VEC-1:0] exp_tt,
    input  logic               f_in,
    output logic [IDX_W-1:0]   abcd,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] tt,
    output logic [4:0]         err_cnt,
    output logic [IDX_W-1:0]   mismatch_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [4:0]       ERR_MAX  = 5'(NUM_VEC);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_VEC-1:0] exp_q, exp_d;
    logic [NUM_VEC-1:0] tt_q, tt_d;
    logic [4:0]         err_q, err_d;
    logic [IDX_W-1:0]   midx_q, midx_d;
    logic               pass_q, pass_d;
    logic               tmr_clr, tmr_en, tmr_tc;

    assign tmr_en  = (state_q == APPLY);
    assign tmr_clr = (state_q != APPLY) || abort;

    tts_dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(tmr_clr),
        .en (tmr_en),
        .tc (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        err_d   = err_q;
        midx_d  = midx_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    exp_d   = exp_tt;
                    tt_d    = '0;
                    err_d   = '0;
                    midx_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                // abort wins over a sample landing in the same cycle
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (tmr_tc) begin
                    tt_d[idx_q] = f_in;
                    if (f_in != exp_q[idx_q]) begin
                        if (err_q == '0) midx_d = idx_q;
                        if (err_q != ERR_MAX) err_d = err_q + 5'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            midx_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            midx_q  <= midx_d;
            pass_q  <= pass_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign abcd         = (state_q == APPLY) ? idx_q :
                          (state_q == DONE)  ? LAST_IDX : '0;
    assign pass         = pass_q;
    assign tt           = tt_q;
    assign err_cnt      = err_q;
    assign mismatch_idx = midx_q;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter DWELL, default 4, meaning cycles each input vector is held before f is sampled; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin an exhaustive 16-vector run; sampled only in IDLE.
REQ-005 abort  input  1  synchronous abort of a run in progress.
REQ-006 exp_tt  input  16  expected truth table; bit i = expected f for vector i; latched on accepted start.
REQ-007 f_in  input  1  output of the 4-input combinational function under test.
REQ-008 abcd  output  4  applied vector {A,B,C,D}, A = MSB, equal to vector index.
REQ-009 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 pass  output  1  1 when the last completed run had zero mismatches; held until next accepted start.
REQ-012 tt  output  16  captured truth table; bit i = sampled f_in for vector i.
REQ-013 err_cnt  output  5  mismatch count of current/last run, range 0..16.
REQ-014 mismatch_idx  output  4  index of first mismatching vector; meaningful only when err_cnt != 0.

Function
REQ-015 FSM states: IDLE, APPLY, DONE.
REQ-016 IDLE: abcd = 4'h0, busy = 0; start=1 and abort=0 -> APPLY with idx = 0, dwell = 0, exp_tt latched, tt/err_cnt/mismatch_idx/pass cleared.
REQ-017 APPLY: abcd = idx; dwell increments each cycle; at the cycle where dwell = DWELL-1, f_in is sampled into tt[idx] and compared with latched exp_tt[idx].
REQ-018 On mismatch: err_cnt increments (saturates at 16); mismatch_idx loads idx only if err_cnt was 0.
REQ-019 After sampling: idx < 15 -> idx+1, dwell = 0, stay APPLY; idx = 15 -> DONE.
REQ-020 DONE: lasts one cycle; done = 1; pass = (final err_cnt == 0); abcd = 4'hF; then IDLE.
REQ-021 Latency: done asserts exactly 16*DWELL + 1 cycles after the edge that accepted start.
REQ-022 DWELL = 1: each vector applied and sampled in the same cycle (f_in path treated as combinational).
REQ-023 start while busy is ignored; start and abort high together in IDLE -> remain IDLE.
REQ-024 abort in APPLY -> IDLE next cycle; no done pulse; pass = 0; tt and err_cnt keep partial values.
REQ-025 abort during DONE is ignored; the run completes normally.
REQ-026 idx wrap 15 -> 0 never occurs within a run; the run ends at index 15.

Reset
REQ-027 rst asserted at any time (including mid-run) forces IDLE immediately: abcd = 0, busy = 0, done = 0, pass = 0, tt = 0, err_cnt = 0, mismatch_idx = 0, idx = 0, dwell = 0, latched exp_tt = 0.
REQ-028 After rst deasserts, the first accepted start begins a clean run from vector 0.

Structure
REQ-029 Shared package holds the state enumeration, NUM_VEC = 16, IDX_W = 4, DWELL_W = 8.
REQ-030 One sub-module, tts_dwell_timer: clear/enable inputs, terminal-count output at DWELL-1; the rest stays in the top level.

Verification
REQ-031 f = A&B&C&D, exp_tt = 16'h8000, DWELL = 4, start pulse -> abcd steps 0..15 every 4 cycles; done at cycle 65; tt = 16'h8000; pass = 1; err_cnt = 0.
REQ-032 f = A^B^C^D, exp_tt = 16'h6996, DWELL = 1 -> done at cycle 17; tt = 16'h6996; pass = 1.
REQ-033 f = A&B&C&D, exp_tt = 16'h8001 -> tt = 16'h8000; err_cnt = 1; mismatch_idx = 0; pass = 0.
REQ-034 f = 0, exp_tt = 16'hFFFF -> err_cnt = 16; mismatch_idx = 0; pass = 0.
REQ-035 Second start at cycle 10 of a run, then abort while abcd = 5 -> second start ignored; IDLE next cycle; no done pulse; pass = 0; abcd = 0.
REQ-036 rst pulsed while abcd = 9 -> all outputs zero the same cycle; new start yields a full 16-vector run with correct tt.
